bus_arb_2to1: RTL
=================

BUS_ARB_2TO1 -- requirements
Module: bus_arb_2to1

Interface
REQ-001 Parameter: PRIO_FIXED, default 0, 0 = round-robin arbitration, 1 = fixed priority with in0 winning.
REQ-002 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-high reset.
REQ-004 Port: in0_valid, input, 1, requester 0 has a word.
REQ-005 Port: in0_data, input, 32, requester 0 word.
REQ-006 Port: in0_ready, output, 1, requester 0 word accepted this cycle.
REQ-007 Port: in1_valid, input, 1, requester 1 has a word.
REQ-008 Port: in1_data, input, 32, requester 1 word.
REQ-009 Port: in1_ready, output, 1, requester 1 word accepted this cycle.
REQ-010 Port: out_valid, output, 1, output register holds a word.
REQ-011 Port: out_data, output, 32, registered granted word.
REQ-012 Port: out_src, output, 1, source of out_data (0 = in0, 1 = in1).
REQ-013 Port: out_ready, input, 1, consumer accepts out_data.

Function
REQ-014 A transfer on any port occurs when valid and ready are both high at a rising edge.
REQ-015 The block has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en = (state==EMPTY) | (out_ready & out_valid); this allows a drain and a refill in the same cycle.
REQ-017 in0_ready and in1_ready are combinational from load_en, the valids and the priority pointer; they never depend on in*_data.
REQ-018 At most one of in0_ready/in1_ready is high in any cycle.
REQ-019 A ready is high only if its own valid is high.
REQ-020 If only one requester is valid and load_en=1, that requester is granted.
REQ-021 Both valid, PRIO_FIXED=0: grant the requester != last_grant.
REQ-022 Both valid, PRIO_FIXED=1: grant in0.
REQ-023 last_grant updates to the granted index on every accepted word.
REQ-024 latency: an accepted word appears on out_data/out_src with out_valid=1 at the next edge.
REQ-025 EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain+accept or on hold.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_src and out_valid hold stable.
REQ-027 No valid + no drain pending: state, out_data and last_grant are unchanged.
REQ-028 out_ready=1 while EMPTY has no effect.

Reset
REQ-029 While reset is asserted: out_valid=0, out_data=32'h0, out_src=0, last_grant=1, state=EMPTY; in0_ready=in1_ready=0.
REQ-030 Reset asserted mid-transfer discards the held word without completing it.
REQ-031 The first arbitration after reset favours in0.

Structure
REQ-032 The shared package holds the state encoding (EMPTY=0, FULL=1), the source encoding (SRC_IN0=0, SRC_IN1=1) and DATA_W=32.
REQ-033 Data selection uses one instance of the existing mux32Bit_2To1, with select = granted index, feeding the output register.
REQ-034 Arbitration and the FSM are local logic, not a separate module.

Verification
REQ-035 Reset check: reset 1 then 0 -> out_valid=0, out_data=0, both readies 0 with no valids.
REQ-036 Single source: in1_valid=1, in1_data=32'hDEADBEEF, out_ready=1 -> in1_ready=1; next cycle out_data=DEADBEEF, out_src=1.
REQ-037 Contention, RR: both valid continuously with in0=32'h11111111, in1=32'h22222222, out_ready=1 -> out_src sequence 0,1,0,1 and one word per cycle.
REQ-038 Contention, fixed (PRIO_FIXED=1): same stimulus -> out_src always 0 and in1_ready never 1.
REQ-039 Backpressure: out_ready=0 for 3 cycles with FULL -> readies 0 and out_data stable; out_ready=1 -> drain and refill in the same cycle.
REQ-040 Mid-op reset: reset pulses while FULL with out_ready=0 -> out_valid=0 asynchronously; next grant goes to in0 when both are valid.

Source files
------------

// File: rtl/bus_arb_2to1_pkg.sv
// Shared definitions for the 2-to-1 bus arbiter: state and source
// encodings plus the datapath width.
package bus_arb_2to1_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic {
        SRC_IN0 = 1'b0,
        SRC_IN1 = 1'b1
    } src_t;

endpackage

// File: rtl/mux32Bit_2To1.sv
// Plain 32-bit two-input multiplexer; sel=0 passes in0, sel=1 passes in1.
module mux32Bit_2To1 (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        sel,
    output logic [31:0] out
);

    // Pure combinational select
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/bus_arb_2to1.sv
// Two-requester bus arbiter with a single-entry registered output.
// Round-robin or fixed-priority (in0 wins) selection; the output register
// can drain and refill in the same cycle so a busy bus moves one word per clock.
module bus_arb_2to1
    import bus_arb_2to1_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready
);

    state_t            state;
    logic              last_grant;
    logic              load_en;
    logic              accept;
    logic              grant_idx;
    logic [DATA_W-1:0] mux_data;

    assign out_valid = (state == FULL);

    // The output register may take a new word when empty or when its current word leaves this cycle
    assign load_en = (state == EMPTY) | (out_ready & out_valid);

    // Pick the granted index from the valids and the priority pointer; data never influences the choice
    always_comb begin
        grant_idx = SRC_IN0;
        if (in0_valid && in1_valid) begin
            if (PRIO_FIXED != 0) begin
                grant_idx = SRC_IN0;
            end else begin
                grant_idx = ~last_grant;
            end
        end else if (in1_valid) begin
            grant_idx = SRC_IN1;
        end
    end

    // Readies are held low while reset is asserted even though the register already reads EMPTY
    assign accept    = load_en & (in0_valid | in1_valid) & ~reset;
    assign in0_ready = accept & (grant_idx == SRC_IN0);
    assign in1_ready = accept & (grant_idx == SRC_IN1);

    mux32Bit_2To1 u_mux (
        .in0 (in0_data),
        .in1 (in1_data),
        .sel (grant_idx),
        .out (mux_data)
    );

    // EMPTY/FULL state machine with the output register and the round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= SRC_IN0;
            last_grant <= SRC_IN1;
        end else begin
            if (accept) begin
                state      <= FULL;
                out_data   <= mux_data;
                out_src    <= grant_idx;
                last_grant <= grant_idx;
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
